usb_fx2_stream_tx: RTL and testbench

Downstream USB egress stage of the OV5640 capture path. Accepts 16-bit RGB565 pixels from the display/readout stage, buffers them in a small internal FIFO, and writes them into the Cypress FX2 EP6 slave FIFO using synchronous slave-FIFO write strobes. It tracks the pixel count per frame, commits any short final packet with PKTEND, and throttles the upstream stage through a request signal.

---
 rtl/usb_fx2_stream_tx_if.sv | 16 +
 rtl/usb_fx2_stream_tx.sv | 113 +++++++++++
 tb/tb_usb_fx2_stream_tx.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_fx2_stream_tx_if.sv
// usb_fx2_stream_tx_if: FX2 slave-FIFO write-side bus.
// flagB_EP6FF: EP6 full flag (active-low).
// USB_DATA/USB_FIFO_ADR: FD bus and FIFOADR.
// USB_SLWR/USB_SLRD/USB_SLOE/PKTEND: active-low strobes.
// The master modport is the stream transmitter; the slave modport is the FX2 side.
interface usb_fx2_stream_tx_if;
  logic        flagB_EP6FF;
  logic [15:0] USB_DATA;
  logic [1:0]  USB_FIFO_ADR;
  logic        USB_SLWR;
  logic        USB_SLRD;
  logic        USB_SLOE;
  logic        PKTEND;
  modport master (input flagB_EP6FF, output USB_DATA, USB_FIFO_ADR, USB_SLWR, USB_SLRD, USB_SLOE, PKTEND);
  modport slave (output flagB_EP6FF, input USB_DATA, USB_FIFO_ADR, USB_SLWR, USB_SLRD, USB_SLOE, PKTEND);
endinterface

// File: rtl/usb_fx2_stream_tx.sv
// usb_fx2_stream_tx: buffers RGB565 pixels and writes them to the FX2 EP6 slave FIFO.
// Upstream side: nframe, data_in and data_pulse are inputs; send_out is the request for more pixels.
// Status outputs: frame_done (one-cycle pulse), plus the sticky ovf_err and frm_err flags.
// fx2: the FX2 write bus, carrying FD, FIFOADR, the SLWR/SLRD/SLOE/PKTEND strobes and the EP6 full flag.
module usb_fx2_stream_tx #(
  parameter int         FRAME_PIXELS = 307200,
  parameter int         PKT_WORDS    = 256,
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [1:0] EP_ADDR      = 2'b10
) (
  input  logic                 usb_clk,
  input  logic                 usb_rst,
  input  logic                 nframe,
  input  logic [15:0]          data_in,
  input  logic                 data_pulse,
  output logic                 send_out,
  output logic                 frame_done,
  output logic                 ovf_err,
  output logic                 frm_err,
  usb_fx2_stream_tx_if.master  fx2
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(PKT_WORDS);
  localparam logic [18:0] FP = 19'(FRAME_PIXELS);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] FOUR = (AW+1)'(4);
  // PKT_GAP is the idle cycle after the last strobe and PKT_STRB launches PKTEND.
  typedef enum logic [2:0] {IDLE, STREAM, PKT_GAP, PKT_STRB, DONE} state_t;
  state_t state_q, state_d;
  logic [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d, free_d;
  logic [18:0] win_q, win_d, wout_q, wout_d;
  logic [PW-1:0] pkt_q, pkt_d;
  logic [15:0] data_q, data_d;
  logic slwr_q, slwr_d, pktend_q, pktend_d, send_q, send_d;
  logic done_q, done_d, ovf_q, ovf_d, frm_q, frm_d;
  logic pop, want, push, full, last;
  always_comb begin
    pop = state_q == STREAM && cnt_q != '0 && fx2.flagB_EP6FF && !nframe;
    full = cnt_q == DEPTH;
    want = state_q == STREAM && data_pulse && win_q < FP && !nframe;
    // A pop in the same cycle frees a slot, so a push into a full FIFO is still legal.
    push = want && (!full || pop);
    last = pop && wout_q == FP - 19'd1;
    // The packet offset reaching all-ones on the last word means the final packet is full-size.
    state_d = nframe ? STREAM
            : last ? (pkt_q != '1 ? PKT_GAP : DONE)
            : state_q == PKT_GAP ? PKT_STRB
            : state_q == PKT_STRB ? DONE
            : state_q == DONE ? IDLE
            : state_q;
    wr_d = nframe ? '0 : wr_q + AW'(push);
    rd_d = nframe ? '0 : rd_q + AW'(pop);
    cnt_d = nframe ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    win_d = nframe ? '0 : win_q + 19'(push);
    wout_d = nframe ? '0 : wout_q + 19'(pop);
    pkt_d = nframe ? '0 : pkt_q + PW'(pop);
    free_d = DEPTH - cnt_d;
    data_d = pop ? mem[rd_q] : data_q;
    slwr_d = !pop;
    pktend_d = !(state_q == PKT_STRB && !nframe);
    // Using next occupancy leaves three free slots for in-flight upstream pulses.
    send_d = state_d == STREAM && free_d >= FOUR;
    done_d = state_q == DONE;
    ovf_d = ovf_q | (want && full && !pop);
    frm_d = frm_q | (nframe && (state_q == STREAM || state_q == PKT_GAP || state_q == PKT_STRB));
  end
  always_ff @(posedge usb_clk)
    if (push) mem[wr_q] <= data_in;
  always_ff @(posedge usb_clk or posedge usb_rst)
    if (usb_rst) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      win_q <= '0;
      wout_q <= '0;
      pkt_q <= '0;
      data_q <= '0;
      slwr_q <= 1'b1;
      pktend_q <= 1'b1;
      send_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q <= 1'b0;
      frm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      win_q <= win_d;
      wout_q <= wout_d;
      pkt_q <= pkt_d;
      data_q <= data_d;
      slwr_q <= slwr_d;
      pktend_q <= pktend_d;
      send_q <= send_d;
      done_q <= done_d;
      ovf_q <= ovf_d;
      frm_q <= frm_d;
    end
  assign fx2.USB_DATA = data_q;
  assign fx2.USB_FIFO_ADR = EP_ADDR;
  assign fx2.USB_SLWR = slwr_q;
  assign fx2.USB_SLRD = 1'b1;
  assign fx2.USB_SLOE = 1'b1;
  assign fx2.PKTEND = pktend_q;
  assign send_out = send_q;
  assign frame_done = done_q;
  assign ovf_err = ovf_q;
  assign frm_err = frm_q;
endmodule

// File: tb/tb_usb_fx2_stream_tx.sv
// tb_usb_fx2_stream_tx: two transmitters (8-word frame with full packets, 22-word frame ending in a short packet) checked against a queue model.
module tb_usb_fx2_stream_tx;
  logic clk = 1'b0, rst = 1'b1;
  logic nf [2], dp [2], fl [2];
  logic [15:0] di [2];
  logic so [2], fd [2], ov [2], fe [2];
  logic [15:0] wdat [2];
  logic [1:0] adr [2];
  logic slwr [2], slrd [2], sloe [2], pkte [2];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  logic [15:0] mq [2][$];
  int win [2], wout [2], pe_at [2], done_at [2];
  bit act [2];
  logic [15:0] e_data [2];
  logic e_slwr [2], e_pe [2], e_done [2], e_send [2], e_ovf [2], e_frm [2];
  logic [15:0] got [2][$];
  int last_wr [2], pe_cyc [2], fd_cyc [2], pe_n [2], fd_n [2];

  usb_fx2_stream_tx_if bus0 ();
  usb_fx2_stream_tx_if bus1 ();

  usb_fx2_stream_tx #(.FRAME_PIXELS(8), .PKT_WORDS(4), .FIFO_DEPTH(16), .EP_ADDR(2'b10)) u0 (
    .usb_clk(clk), .usb_rst(rst), .nframe(nf[0]), .data_in(di[0]), .data_pulse(dp[0]),
    .send_out(so[0]), .frame_done(fd[0]), .ovf_err(ov[0]), .frm_err(fe[0]), .fx2(bus0));
  usb_fx2_stream_tx #(.FRAME_PIXELS(22), .PKT_WORDS(4), .FIFO_DEPTH(16), .EP_ADDR(2'b10)) u1 (
    .usb_clk(clk), .usb_rst(rst), .nframe(nf[1]), .data_in(di[1]), .data_pulse(dp[1]),
    .send_out(so[1]), .frame_done(fd[1]), .ovf_err(ov[1]), .frm_err(fe[1]), .fx2(bus1));

  assign bus0.flagB_EP6FF = fl[0];
  assign bus1.flagB_EP6FF = fl[1];
  assign wdat[0] = bus0.USB_DATA;
  assign wdat[1] = bus1.USB_DATA;
  assign adr[0] = bus0.USB_FIFO_ADR;
  assign adr[1] = bus1.USB_FIFO_ADR;
  assign slwr[0] = bus0.USB_SLWR;
  assign slwr[1] = bus1.USB_SLWR;
  assign slrd[0] = bus0.USB_SLRD;
  assign slrd[1] = bus1.USB_SLRD;
  assign sloe[0] = bus0.USB_SLOE;
  assign sloe[1] = bus1.USB_SLOE;
  assign pkte[0] = bus0.PKTEND;
  assign pkte[1] = bus1.PKTEND;

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1, "watchdog expired");
  end

  function automatic int fp_of(input int k);
    return k == 0 ? 8 : 22;
  endfunction

  task automatic check(input string nm, input int k, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[%0d] at cycle %0d: got %0h want %0h", nm, k, cyc, a, e);
    end
  endtask

  // One clock of the frame rules: pops need a non-empty buffer and EP6 not full,
  // pushes need room (or a same-cycle pop) and an unfinished frame.
  task automatic model_step(input int k);
    bit pop;
    e_slwr[k] = 1'b1;
    if (rst) begin
      mq[k].delete();
      act[k] = 0;
      win[k] = 0;
      wout[k] = 0;
      pe_at[k] = -1;
      done_at[k] = -1;
      e_data[k] = '0;
      e_pe[k] = 1'b1;
      e_done[k] = 1'b0;
      e_send[k] = 1'b0;
      e_ovf[k] = 1'b0;
      e_frm[k] = 1'b0;
      return;
    end
    if (nf[k]) begin
      if (act[k] || pe_at[k] >= cyc) e_frm[k] = 1'b1;
      if (pe_at[k] >= cyc) begin
        pe_at[k] = -1;
        done_at[k] = -1;
      end
      mq[k].delete();
      win[k] = 0;
      wout[k] = 0;
      act[k] = 1;
    end else begin
      pop = act[k] && mq[k].size() > 0 && fl[k] == 1'b1;
      if (pop) begin
        e_data[k] = mq[k].pop_front();
        e_slwr[k] = 1'b0;
        wout[k]++;
      end
      if (act[k] && dp[k] == 1'b1 && win[k] < fp_of(k)) begin
        if (mq[k].size() < 16) begin
          mq[k].push_back(di[k]);
          win[k]++;
        end else e_ovf[k] = 1'b1;
      end
      if (pop && wout[k] == fp_of(k)) begin
        act[k] = 0;
        if (fp_of(k) % 4 != 0) begin
          pe_at[k] = cyc + 2;
          done_at[k] = cyc + 3;
        end else done_at[k] = cyc + 1;
      end
    end
    e_pe[k] = pe_at[k] != cyc;
    e_done[k] = done_at[k] == cyc;
    e_send[k] = act[k] && (16 - mq[k].size() >= 4);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    for (int k = 0; k < 2; k++) model_step(k);
  end

  initial forever begin
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("USB_DATA", k, 32'(wdat[k]), rst ? 32'd0 : 32'(e_data[k]));
      check("USB_SLWR", k, 32'(slwr[k]), rst ? 32'd1 : 32'(e_slwr[k]));
      check("PKTEND", k, 32'(pkte[k]), rst ? 32'd1 : 32'(e_pe[k]));
      check("frame_done", k, 32'(fd[k]), rst ? 32'd0 : 32'(e_done[k]));
      check("send_out", k, 32'(so[k]), rst ? 32'd0 : 32'(e_send[k]));
      check("ovf_err", k, 32'(ov[k]), rst ? 32'd0 : 32'(e_ovf[k]));
      check("frm_err", k, 32'(fe[k]), rst ? 32'd0 : 32'(e_frm[k]));
      check("USB_FIFO_ADR", k, 32'(adr[k]), 32'd2);
      check("USB_SLRD", k, 32'(slrd[k]), 32'd1);
      check("USB_SLOE", k, 32'(sloe[k]), 32'd1);
      if (slwr[k] == 1'b0) begin
        got[k].push_back(wdat[k]);
        last_wr[k] = cyc;
      end
      if (pkte[k] == 1'b0) begin
        pe_n[k]++;
        pe_cyc[k] = cyc;
      end
      if (fd[k] == 1'b1) begin
        fd_n[k]++;
        fd_cyc[k] = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int k);
    nf[k] = 1'b1;
    tick();
    nf[k] = 1'b0;
  endtask

  task automatic wait_fd(input int k, input int budget);
    int c0;
    int i;
    c0 = fd_n[k];
    i = 0;
    while (fd_n[k] == c0 && i < budget) begin
      tick();
      i++;
    end
    check("frame_done_seen", k, 32'(fd_n[k] - c0), 32'd1);
  endtask

  initial begin
    int p, extra, fall, c0, j, pe0, sz;
    for (int k = 0; k < 2; k++) begin
      nf[k] = 1'b0;
      dp[k] = 1'b0;
      fl[k] = 1'b1;
      di[k] = '0;
    end
    repeat (3) tick();
    check("rst_SLWR", 0, 32'(slwr[0]), 32'd1);
    check("rst_PKTEND", 0, 32'(pkte[0]), 32'd1);
    check("rst_send_out", 0, 32'(so[0]), 32'd0);
    check("rst_USB_DATA", 0, 32'(wdat[0]), 32'd0);
    check("rst_FIFO_ADR", 1, 32'(adr[1]), 32'd2);
    rst = 1'b0;
    tick();

    // Basic frame, 8 words in two full packets: no PKTEND, frame_done right after the last strobe.
    got[0].delete();
    pe0 = pe_n[0];
    start_frame(0);
    for (int i = 0; i < 8; i++) begin
      dp[0] = 1'b1;
      di[0] = 16'(i + 1);
      tick();
    end
    dp[0] = 1'b0;
    wait_fd(0, 50);
    check("basic_count", 0, 32'(got[0].size()), 32'd8);
    for (int i = 0; i < got[0].size() && i < 8; i++) check("basic_word", 0, 32'(got[0][i]), 32'(i + 1));
    check("basic_no_pktend", 0, 32'(pe_n[0] - pe0), 32'd0);
    check("basic_done_lat", 0, 32'(fd_cyc[0] - last_wr[0]), 32'd1);

    // 22-word frame ends with a 2-word packet: idle cycle, PKTEND, then frame_done.
    got[1].delete();
    pe0 = pe_n[1];
    start_frame(1);
    for (int i = 0; i < 22; i++) begin
      dp[1] = 1'b1;
      di[1] = 16'(16'h0100 + i);
      tick();
    end
    dp[1] = 1'b0;
    wait_fd(1, 80);
    check("short_count", 1, 32'(got[1].size()), 32'd22);
    for (int i = 0; i < got[1].size() && i < 22; i++) check("short_word", 1, 32'(got[1][i]), 32'(16'h0100 + i));
    check("short_pktend_n", 1, 32'(pe_n[1] - pe0), 32'd1);
    check("short_pktend_lat", 1, 32'(pe_cyc[1] - last_wr[1]), 32'd2);
    check("short_done_lat", 1, 32'(fd_cyc[1] - pe_cyc[1]), 32'd1);

    // Backpressure: EP6 full for 20 cycles; source stops 3 pulses after send_out falls.
    got[1].delete();
    fl[1] = 1'b0;
    start_frame(1);
    p = 0;
    extra = 0;
    fall = -1;
    repeat (20) begin
      if (so[1] == 1'b0 && fall < 0) fall = p;
      dp[1] = p < 22 && (so[1] == 1'b1 || extra < 3);
      if (dp[1] == 1'b1 && so[1] == 1'b0) extra++;
      di[1] = 16'(16'h0200 + p);
      if (dp[1] == 1'b1) p++;
      tick();
    end
    dp[1] = 1'b0;
    check("bp_no_strobe", 1, 32'(got[1].size()), 32'd0);
    check("bp_fall_occ", 1, 32'(fall), 32'd13);
    check("bp_ovf", 1, 32'(ov[1]), 32'd0);
    fl[1] = 1'b1;
    c0 = fd_n[1];
    j = 0;
    while (fd_n[1] == c0 && j < 200) begin
      dp[1] = so[1] == 1'b1 && p < 22;
      di[1] = 16'(16'h0200 + p);
      if (dp[1] == 1'b1) p++;
      tick();
      j++;
    end
    dp[1] = 1'b0;
    check("bp_frame_done", 1, 32'(fd_n[1] - c0), 32'd1);
    check("bp_count", 1, 32'(got[1].size()), 32'd22);
    for (int i = 0; i < got[1].size() && i < 22; i++) check("bp_word", 1, 32'(got[1][i]), 32'(16'h0200 + i));
    check("bp_ovf_end", 1, 32'(ov[1]), 32'd0);

    // Overflow: 20 back-to-back pushes into a stalled 16-entry buffer.
    got[1].delete();
    fl[1] = 1'b0;
    start_frame(1);
    for (int i = 0; i < 20; i++) begin
      dp[1] = 1'b1;
      di[1] = 16'(16'h0300 + i);
      tick();
    end
    dp[1] = 1'b0;
    tick();
    check("ovf_set", 1, 32'(ov[1]), 32'd1);
    fl[1] = 1'b1;
    repeat (30) tick();
    check("ovf_count", 1, 32'(got[1].size()), 32'd16);
    for (int i = 0; i < got[1].size() && i < 16; i++) check("ovf_word", 1, 32'(got[1][i]), 32'(16'h0300 + i));

    // Abort: 3 words parked behind a full EP6, then nframe flushes them.
    got[0].delete();
    fl[0] = 1'b0;
    start_frame(0);
    for (int i = 0; i < 3; i++) begin
      dp[0] = 1'b1;
      di[0] = 16'(16'h0041 + i);
      tick();
    end
    dp[0] = 1'b0;
    tick();
    check("abort_pre_frm", 0, 32'(fe[0]), 32'd0);
    start_frame(0);
    check("abort_frm", 0, 32'(fe[0]), 32'd1);
    fl[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      dp[0] = 1'b1;
      di[0] = 16'(16'h0051 + i);
      tick();
    end
    dp[0] = 1'b0;
    wait_fd(0, 50);
    check("abort_count", 0, 32'(got[0].size()), 32'd8);
    for (int i = 0; i < got[0].size() && i < 8; i++) check("abort_word", 0, 32'(got[0][i]), 32'(16'h0051 + i));

    // Reset while a strobe is on the bus.
    start_frame(0);
    j = 0;
    while (slwr[0] !== 1'b0 && j < 10) begin
      dp[0] = 1'b1;
      di[0] = 16'(16'h0060 + j);
      tick();
      j++;
    end
    check("rst_strobe_seen", 0, 32'(slwr[0]), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_now_SLWR", 0, 32'(slwr[0]), 32'd1);
    check("rst_now_PKTEND", 0, 32'(pkte[0]), 32'd1);
    check("rst_now_send_out", 0, 32'(so[0]), 32'd0);
    dp[0] = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_send_out", 0, 32'(so[0]), 32'd0);
    sz = got[0].size();
    dp[0] = 1'b1;
    di[0] = 16'h0077;
    tick();
    dp[0] = 1'b0;
    repeat (4) tick();
    check("idle_push_ignored", 0, 32'(got[0].size()), 32'(sz));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
